// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and constants for the two-requester UART transmit scheduler.
package uart_tx_scheduler_pkg;

  localparam int unsigned MAX_BYTES  = 4;
  localparam int unsigned SETTLE_DEF = 2;
  localparam int unsigned FRAME_W    = 8 * MAX_BYTES;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GRANT    = 3'd1,
    ST_WAIT_RDY = 3'd2,
    ST_WRITE    = 3'd3,
    ST_SETTLE   = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  function automatic logic [2:0] clamp_len(input logic [2:0] len);
    return (len > 3'(MAX_BYTES)) ? 3'(MAX_BYTES) : len;
  endfunction

  // Left-justify the frame so the first byte to send sits in the top byte lane.
  function automatic logic [FRAME_W-1:0] align_frame(input logic [FRAME_W-1:0] data,
                                                     input logic [2:0]         len);
    logic [FRAME_W-1:0] r;
    case (len)
      3'd1:    r = {data[7:0],  24'h0};
      3'd2:    r = {data[15:0], 16'h0};
      3'd3:    r = {data[23:0], 8'h0};
      default: r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Frame request handshake between one requester (master) and the scheduler (slave).
interface uart_tx_scheduler_if;
  logic                                      valid;
  logic [uart_tx_scheduler_pkg::FRAME_W-1:0] data;
  logic [2:0]                                len;
  logic                                      ack;
  logic                                      done;

  modport master (output valid, data, len, input ack, done);
  modport slave  (input valid, data, len, output ack, done);
endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter; the last-grant pointer moves only when a grant is taken.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] gnt
);

  logic last_q, last_d;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
  end

  always_comb begin
    last_d = last_q;
    if (grant_en && (gnt != 2'b00)) last_d = gnt[1];
  end

  // Pointer resets to requester 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Arbitrates whole frames from two requesters and streams their bytes to a UART
// holding register, pacing each write strobe by a fixed settle window.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int unsigned SETTLE = SETTLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_tx_scheduler_if.slave   req0,
  uart_tx_scheduler_if.slave   req1,
  input  logic                 txrdy,
  output logic [7:0]           data_out,
  output logic                 wen,
  output logic                 busy
);

  // The WRITE cycle counts as the first settle cycle, so SETTLE holds SETTLE-1 cycles.
  localparam bit         HAS_SETTLE  = (SETTLE > 1);
  localparam logic [2:0] SETTLE_LAST = HAS_SETTLE ? 3'(SETTLE - 2) : 3'd0;

  state_t             state_q, state_d;
  logic               owner_q, owner_d;
  logic               ack0_q, ack0_d, ack1_q, ack1_d;
  logic               done0_q, done0_d, done1_q, done1_d;
  logic               wen_q, wen_d, busy_q, busy_d;
  logic [7:0]         data_out_q, data_out_d;
  logic [2:0]         cnt_q, cnt_d, settle_q, settle_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [2:0]         len_q, len_d;

  logic [1:0]         gnt;
  logic               grant_en, settled, frame_end;
  logic [FRAME_W-1:0] sel_data;
  logic [2:0]         sel_len;

  assign grant_en  = (state_q == ST_IDLE) && (req0.valid || req1.valid);
  assign sel_data  = gnt[1] ? req1.data : req0.data;
  assign sel_len   = clamp_len(gnt[1] ? req1.len : req0.len);
  assign frame_end = ((cnt_q + 3'd1) >= len_q);
  assign settled   = ((state_q == ST_WRITE) && !HAS_SETTLE) ||
                     ((state_q == ST_SETTLE) && (settle_q == SETTLE_LAST));

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      ({req1.valid, req0.valid}),
    .grant_en (grant_en),
    .gnt      (gnt)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    wen_d      = 1'b1;
    data_out_d = data_out_q;
    busy_d     = busy_q;
    cnt_d      = cnt_q;
    settle_d   = settle_q;
    unique case (state_q)
      ST_IDLE: if (grant_en) begin
        state_d = ST_GRANT;
        owner_d = gnt[1];
        ack0_d  = gnt[0];
        ack1_d  = gnt[1];
        busy_d  = 1'b1;
        cnt_d   = 3'd0;
      end
      ST_GRANT: if (len_q == 3'd0) begin
        state_d = ST_DONE;
        done0_d = ~owner_q;
        done1_d = owner_q;
      end else begin
        state_d = ST_WAIT_RDY;
      end
      ST_WAIT_RDY: if (txrdy) begin
        state_d    = ST_WRITE;
        wen_d      = 1'b0;
        data_out_d = frame_q[FRAME_W-1 -: 8];
      end
      ST_WRITE: begin
        settle_d = 3'd0;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: settle_d = settle_q + 3'd1;
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
    if (settled) begin
      if (frame_end) begin
        state_d = ST_DONE;
        done0_d = ~owner_q;
        done1_d = owner_q;
      end else begin
        state_d = ST_WAIT_RDY;
        cnt_d   = cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      wen_q      <= 1'b1;
      data_out_q <= 8'h00;
      busy_q     <= 1'b0;
      cnt_q      <= 3'd0;
      settle_q   <= 3'd0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      wen_q      <= wen_d;
      data_out_q <= data_out_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      settle_q   <= settle_d;
    end
  end

  // Frame shift register: loaded at grant, advanced one byte per accepted write.
  always_comb begin
    frame_d = frame_q;
    len_d   = len_q;
    if (grant_en) begin
      len_d   = sel_len;
      frame_d = align_frame(sel_data, sel_len);
    end else if ((state_q == ST_WAIT_RDY) && txrdy) begin
      frame_d = frame_q << 8;
    end
  end

  always_ff @(posedge clk) begin
    frame_q <= frame_d;
    len_q   <= len_d;
  end

  assign req0.ack  = ack0_q;
  assign req1.ack  = ack1_q;
  assign req0.done = done0_q;
  assign req1.done = done1_q;
  assign data_out  = data_out_q;
  assign wen       = wen_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: table of single frames plus tie,
// backpressure, non-preemption and mid-frame reset sequences.
module tb_uart_tx_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       txrdy = 1'b0;
  logic [7:0] data_out;
  logic       wen, busy;

  uart_tx_scheduler_if r0();
  uart_tx_scheduler_if r1();

  uart_tx_scheduler #(.SETTLE(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (r0),
    .req1     (r1),
    .txrdy    (txrdy),
    .data_out (data_out),
    .wen      (wen),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observer: logs every write strobe, ack order, done pulses and data_out hold.
  logic [7:0] wq[$];
  int         wcyc[$];
  bit         ackq[$];
  int         done_cnt = 0;
  int         hold_bad = 0;
  bit         wen_prev_low = 1'b0;
  logic [7:0] byte_prev = 8'h00;

  always @(negedge clk) begin
    if (rst_n) begin
      if (!wen) begin wq.push_back(data_out); wcyc.push_back(cyc); end
      if (r0.ack) ackq.push_back(1'b0);
      if (r1.ack) ackq.push_back(1'b1);
      if (r0.done || r1.done) done_cnt++;
      if (wen_prev_low && (data_out != byte_prev)) hold_bad++;
      wen_prev_low = !wen;
      byte_prev    = data_out;
    end else begin
      wen_prev_low = 1'b0;
    end
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input bit who, input logic [2:0] len, input logic [31:0] data,
                           output int t_ack, output int t_done);
    t_ack  = -1;
    t_done = -1;
    if (who) begin r1.len = len; r1.data = data; r1.valid = 1'b1; end
    else     begin r0.len = len; r0.data = data; r0.valid = 1'b1; end
    for (int i = 0; i < 50 && t_ack < 0; i++) begin
      @(negedge clk);
      if (who ? r1.ack : r0.ack) begin
        t_ack = cyc;
        chk("busy_at_ack", {31'd0, busy}, 32'd1);
      end
    end
    r0.valid = 1'b0;
    r1.valid = 1'b0;
    for (int i = 0; i < 300 && t_done < 0 && t_ack >= 0; i++) begin
      @(negedge clk);
      if (who ? r1.done : r0.done) t_done = cyc;
    end
    chk("frame_handshake", {31'd0, (t_ack >= 0 && t_done >= 0)}, 32'd1);
    if (t_done >= 0) begin
      @(negedge clk);
      chk("busy_after_done", {31'd0, busy}, 32'd0);
    end
  endtask

  typedef struct {
    bit          who;
    logic [2:0]  len;
    logic [31:0] data;
    int          nb;
    logic [31:0] exp_bytes;
    int          lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int  t_ack, t_done, b0, a0, t0d, t1a, t1d, rise, stall, nb_hold, d0;
    bit  raised, seen, re;
    int  rearm, n_done;

    vecs[0] = '{1'b0, 3'd3, 32'h00A1B2C3, 3, 32'hA1B2C300, 10};
    vecs[1] = '{1'b1, 3'd0, 32'hDEADBEEF, 0, 32'h00000000, 1};
    vecs[2] = '{1'b0, 3'd7, 32'h11223344, 4, 32'h11223344, 13};
    vecs[3] = '{1'b1, 3'd1, 32'hDEADBEEF, 1, 32'hEF000000, 4};
    vecs[4] = '{1'b0, 3'd2, 32'hCAFE1234, 2, 32'h12340000, 7};
    vecs[5] = '{1'b1, 3'd4, 32'h89ABCDEF, 4, 32'h89ABCDEF, 13};
    vecs[6] = '{1'b0, 3'd5, 32'h0F1E2D3C, 4, 32'h0F1E2D3C, 13};

    r0.valid = 1'b0; r0.data = '0; r0.len = '0;
    r1.valid = 1'b0; r1.data = '0; r1.len = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_wen",      {31'd0, wen},      32'd1);
    chk("rst_data_out", {24'd0, data_out}, 32'd0);
    chk("rst_busy",     {31'd0, busy},     32'd0);
    chk("rst_ack",      {30'd0, r1.ack, r0.ack},   32'd0);
    chk("rst_done",     {30'd0, r1.done, r0.done}, 32'd0);
    rst_n = 1'b1;
    txrdy = 1'b1;
    @(negedge clk);

    // Tie after reset: req0 first; req0 re-requests while req1 waits, so req1 goes next.
    a0 = ackq.size(); b0 = wq.size();
    r0.len = 3'd1; r0.data = 32'h55; r0.valid = 1'b1;
    r1.len = 3'd1; r1.data = 32'h66; r1.valid = 1'b1;
    re = 1'b0; rearm = -1; n_done = 0;
    for (int i = 0; i < 200 && n_done < 3; i++) begin
      @(negedge clk);
      if (r0.ack) begin
        r0.valid = 1'b0;
        if (!re) rearm = cyc + 2;
      end
      if (r1.ack) r1.valid = 1'b0;
      if (!re && rearm >= 0 && cyc >= rearm) begin
        r0.data = 32'h77; r0.valid = 1'b1; re = 1'b1;
      end
      if (r0.done || r1.done) n_done++;
    end
    chk("tie_frames_done", n_done, 3);
    chk("tie_ack_count", ackq.size() - a0, 3);
    chk("tie_ack_first",  {31'd0, ackq[a0]},     32'd0);
    chk("tie_ack_second", {31'd0, ackq[a0 + 1]}, 32'd1);
    chk("tie_ack_third",  {31'd0, ackq[a0 + 2]}, 32'd0);
    chk("tie_byte0", {24'd0, wq[b0]},     32'h55);
    chk("tie_byte1", {24'd0, wq[b0 + 1]}, 32'h66);
    chk("tie_byte2", {24'd0, wq[b0 + 2]}, 32'h77);
    r0.valid = 1'b0;
    r1.valid = 1'b0;
    repeat (2) @(negedge clk);

    // Table of single frames with txrdy held high
    foreach (vecs[i]) begin
      b0 = wq.size(); a0 = ackq.size();
      run_frame(vecs[i].who, vecs[i].len, vecs[i].data, t_ack, t_done);
      chk($sformatf("v%0d_nbytes", i), wq.size() - b0, vecs[i].nb);
      chk($sformatf("v%0d_latency", i), t_done - t_ack, vecs[i].lat);
      chk($sformatf("v%0d_owner", i),
          {31'd0, (ackq.size() == a0 + 1) && (ackq[a0] == vecs[i].who)}, 32'd1);
      for (int k = 0; k < vecs[i].nb && (b0 + k) < wq.size(); k++) begin
        chk($sformatf("v%0d_byte%0d", i, k), {24'd0, wq[b0 + k]},
            {24'd0, vecs[i].exp_bytes[31 - 8 * k -: 8]});
        if (k == 0) chk($sformatf("v%0d_first_write", i), wcyc[b0], t_ack + 2);
        else        chk($sformatf("v%0d_spacing%0d", i, k), wcyc[b0 + k] - wcyc[b0 + k - 1], 3);
      end
      repeat (2) @(negedge clk);
    end

    // Backpressure: txrdy low for 20 cycles right after byte 1
    b0 = wq.size(); t_ack = -1; t_done = -1; rise = -1; stall = -1; nb_hold = -1;
    r0.len = 3'd3; r0.data = 32'h00102030; r0.valid = 1'b1; txrdy = 1'b1;
    for (int i = 0; i < 200 && t_done < 0; i++) begin
      @(negedge clk);
      if (r0.ack) begin t_ack = cyc; r0.valid = 1'b0; end
      if (!wen && stall < 0) begin txrdy = 1'b0; stall = cyc; end
      if (stall >= 0 && rise < 0 && cyc == stall + 20) begin
        nb_hold = wq.size() - b0;
        txrdy = 1'b1;
        rise = cyc;
      end
      if (r0.done) t_done = cyc;
    end
    chk("bp_done_seen", {31'd0, (t_done >= 0)}, 32'd1);
    chk("bp_no_wen_in_hold", nb_hold, 1);
    chk("bp_byte2_timing", wcyc[b0 + 1], rise + 1);
    chk("bp_byte1", {24'd0, wq[b0]},     32'h10);
    chk("bp_byte2", {24'd0, wq[b0 + 1]}, 32'h20);
    chk("bp_byte3", {24'd0, wq[b0 + 2]}, 32'h30);
    chk("bp_latency", t_done - t_ack, 28);
    repeat (2) @(negedge clk);

    // Non-preemption: req1 arrives during req0's frame
    b0 = wq.size(); a0 = ackq.size(); t0d = -1; t1a = -1; t1d = -1; raised = 1'b0;
    r0.len = 3'd2; r0.data = 32'h0000ABCD; r0.valid = 1'b1;
    for (int i = 0; i < 200 && t1d < 0; i++) begin
      @(negedge clk);
      if (r0.ack) r0.valid = 1'b0;
      if (!wen && !raised) begin
        r1.len = 3'd1; r1.data = 32'hEE; r1.valid = 1'b1; raised = 1'b1;
      end
      if (r0.done) t0d = cyc;
      if (r1.ack) begin t1a = cyc; r1.valid = 1'b0; end
      if (r1.done) t1d = cyc;
    end
    chk("np_req1_done_seen", {31'd0, (t1d >= 0)}, 32'd1);
    chk("np_req1_ack_after_done", t1a, t0d + 2);
    chk("np_ack_order", {30'd0, ackq[a0 + 1], ackq[a0]}, 32'b10);
    chk("np_bytes", {8'd0, wq[b0], wq[b0 + 1], wq[b0 + 2]}, 32'h00ABCDEE);
    repeat (2) @(negedge clk);

    // Reset in the middle of a 4-byte frame
    seen = 1'b0;
    r0.len = 3'd4; r0.data = 32'hAABBCCDD; r0.valid = 1'b1;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (r0.ack) r0.valid = 1'b0;
      if (!wen) seen = 1'b1;
    end
    chk("mr_first_write_seen", {31'd0, seen}, 32'd1);
    chk("mr_first_byte", {24'd0, data_out}, 32'hAA);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("mr_wen_async",  {31'd0, wen},  32'd1);
    chk("mr_busy_async", {31'd0, busy}, 32'd0);
    chk("mr_data_async", {24'd0, data_out}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mr_no_done", done_cnt - d0, 0);
    chk("mr_idle_busy", {31'd0, busy}, 32'd0);
    b0 = wq.size();
    run_frame(1'b0, 3'd4, 32'hAABBCCDD, t_ack, t_done);
    chk("mr_refr_nbytes", wq.size() - b0, 4);
    chk("mr_refr_bytes", {wq[b0], wq[b0 + 1], wq[b0 + 2], wq[b0 + 3]}, 32'hAABBCCDD);
    chk("mr_refr_latency", t_done - t_ack, 13);

    chk("data_out_hold", hold_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
